// File: rtl/ram_sp_sr_sw.sv
// ram_sp_sr_sw
// Single-port static RAM with a synchronous read, a synchronous write and one
// shared bidirectional data bus. Sized by parameters; the CPU uses 64-bit
// words with a 12-bit address.
//
// Ports
//   clk      rising-edge clock, all state updates here
//   rst      asynchronous active-high reset, clears the read register only
//   address  word address
//   data     bidirectional bus: write data in, read data out, high-Z otherwise
//   cs       chip select, active-high
//   we       1 = write, 0 = read
//   oe       output enable, active-high
module ram_sp_sr_sw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  // Depth held one bit wider than the address so that a full 2^ADDR_WIDTH
  // depth is representable and the range compare stays width-matched.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] data_out;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drive;

  assign in_range = ({1'b0, address} < DEPTH_L);
  assign wr_en    = cs && we;
  assign rd_en    = cs && !we && oe;
  assign drive    = cs && oe && !we;

  // The array has no reset: contents survive rst. rst still blocks writes
  // while it is held, so it appears here as a plain qualifier.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && in_range) begin
      mem[address] <= data;
    end
  end

  // Read register: cleared asynchronously, otherwise loads only on an
  // enabled read and holds in every other case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= in_range ? mem[address] : '0;
    end
  end

  // Drive is purely combinational in cs/oe/we; it never overlaps the
  // master's drive window (cs=1, we=1).
  assign data = drive ? data_out : 'z;

endmodule

// File: tb/tb_ram_sp_sr_sw.sv
module tb_ram_sp_sr_sw;

  localparam int DW = 64;
  localparam int AW = 12;

  // Pulled-up bus: when neither side drives, every bit reads 1. No word
  // stored during this test is all-ones, so all-ones means "released".
  localparam logic [DW-1:0] BUS_IDLE = '1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] address;
  logic          cs;
  logic          we;
  logic          oe;
  logic          drv_en;
  logic [DW-1:0] drv_val;
  tri1  [DW-1:0] data;

  int n_cmp;
  int n_err;

  assign data = drv_en ? drv_val : 'z;

  ram_sp_sr_sw #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .data   (data),
    .cs     (cs),
    .we     (we),
    .oe     (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge.
  task automatic set_in(input logic c, input logic w, input logic o,
                        input logic [AW-1:0] a, input logic de,
                        input logic [DW-1:0] dv);
    @(negedge clk);
    cs      = c;
    we      = w;
    oe      = o;
    address = a;
    drv_en  = de;
    drv_val = dv;
  endtask

  // Let one rising edge pass and settle just after it.
  task automatic edge_pass();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    cs      = 1'b0;
    we      = 1'b0;
    oe      = 1'b0;
    address = '0;
    drv_en  = 1'b0;
    drv_val = '0;

    // Reset state
    #2;
    check("rst_bus_deselected", data, BUS_IDLE);
    cs = 1'b1; oe = 1'b1; we = 1'b0;
    #1;
    check("rst_bus_reads_zero", data, 64'h0);
    edge_pass();
    check("rst_held_across_edge", data, 64'h0);

    set_in(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'h0);
    rst = 1'b0;

    // Write gating
    set_in(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 64'hA5);
    edge_pass();
    set_in(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 64'hA5);
    edge_pass();
    set_in(1'b1, 1'b1, 1'b0, 12'h018, 1'b1, 64'h1234);
    edge_pass();
    set_in(1'b1, 1'b1, 1'b0, 12'h002, 1'b1, 64'h5A);
    edge_pass();
    // Deselected write must not overwrite 0x002
    set_in(1'b0, 1'b1, 1'b0, 12'h002, 1'b1, 64'hFF);
    edge_pass();

    // Read gating: oe=0 keeps the bus released and data_out unchanged
    set_in(1'b1, 1'b0, 1'b0, 12'h018, 1'b0, 64'h0);
    #1;
    check("oe0_bus_released", data, BUS_IDLE);
    edge_pass();
    check("oe0_after_edge_released", data, BUS_IDLE);
    set_in(1'b1, 1'b0, 1'b1, 12'h018, 1'b0, 64'h0);
    #1;
    check("oe1_shows_held_zero", data, 64'h0);

    // Read latency
    edge_pass();
    check("read_018", data, 64'h1234);
    set_in(1'b1, 1'b0, 1'b1, 12'h019, 1'b0, 64'h0);
    #1;
    check("addr_change_no_early_update", data, 64'h1234);
    edge_pass();
    set_in(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 64'h0);
    edge_pass();
    check("read_000", data, 64'hA5);

    // Deselect and reselect
    set_in(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 64'h0);
    #1;
    check("cs0_bus_released", data, BUS_IDLE);
    edge_pass();
    set_in(1'b1, 1'b1, 1'b1, 12'h101, 1'b1, 64'h123456789AB);
    #1;
    check("write_no_dut_drive", data, 64'h123456789AB);
    edge_pass();
    set_in(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 64'h0);
    #1;
    check("reselect_shows_held", data, 64'hA5);
    edge_pass();
    check("reread_000", data, 64'hA5);
    set_in(1'b1, 1'b0, 1'b1, 12'h101, 1'b0, 64'h0);
    edge_pass();
    check("read_101", data, 64'h123456789AB);
    set_in(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 64'h0);
    edge_pass();
    check("read_000_pre_rst", data, 64'hA5);

    // Reset mid-operation, between edges
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_clear", data, 64'h0);
    // A write attempted while rst is held must be ignored
    set_in(1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 64'hEE);
    edge_pass();
    set_in(1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_held_zero", data, 64'h0);
    edge_pass();
    check("array_kept_over_rst", data, 64'hA5);

    set_in(1'b1, 1'b0, 1'b1, 12'h002, 1'b0, 64'h0);
    edge_pass();
    check("cs0_write_ignored", data, 64'h5A);

    // Back-to-back writes to 0x0FF
    set_in(1'b1, 1'b1, 1'b0, 12'h0FF, 1'b1, 64'h1);
    edge_pass();
    set_in(1'b1, 1'b1, 1'b0, 12'h0FF, 1'b1, 64'h2);
    edge_pass();
    set_in(1'b1, 1'b0, 1'b1, 12'h0FF, 1'b0, 64'h0);
    edge_pass();
    check("b2b_write_last_wins", data, 64'h2);

    set_in(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 64'h0);
    #1;
    check("final_released", data, BUS_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
